reg_wb_arbiter: RTL and testbench

Sequences the register file's single write port. Arbitrates writeback from the execute (ALU) and memory (load) units, with round-robin on contention. Keeps a per-register busy scoreboard, set at issue and cleared at commit, and raises an issue stall on RAW/WAW hazards. Sits between the execute/memory stages and the register file's wren/rd_addr/reg_data inputs.

---
 rtl/reg_wb_arbiter_pkg.sv | 24 ++
 rtl/reg_wb_arbiter_if.sv | 50 +++++
 rtl/reg_wb_arbiter_wb_scoreboard.sv | 66 ++++++
 rtl/reg_wb_arbiter.sv | 81 ++++++++
 tb/tb_reg_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Optional feature macro: WB_BYPASS_EN (writeback-to-issue operand bypass).
package reg_wb_arbiter_pkg;

  localparam int XLEN = 32;  // data width
  localparam int NREG = 32;  // architectural registers
  localparam int AW   = 5;   // log2(NREG)

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xdata_t;

  // Grant encoding; the round-robin pointer reuses it to name a source.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_EXEC = 2'd1,
    GNT_MEM  = 2'd2
  } gnt_e;

  // The source that gets priority after src has been granted.
  function automatic gnt_e other_src(gnt_e src);
    return (src == GNT_EXEC) ? GNT_MEM : GNT_EXEC;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Issue, writeback-request and register-file-write signals of the arbiter.
// slave: arbiter view; master: pipeline / register-file view.
// Optional feature macro: WB_BYPASS_EN (drives byp1_hit / byp2_hit).
interface reg_wb_arbiter_if;
  import reg_wb_arbiter_pkg::*;

  // Decode issue
  logic      issue_valid;
  logic      issue_rd_we;
  reg_addr_t issue_rd;
  reg_addr_t issue_rs1;
  reg_addr_t issue_rs2;
  logic      stall;

  // ALU writeback request
  logic      exec_valid;
  reg_addr_t exec_rd;
  xdata_t    exec_data;
  logic      exec_ready;

  // Load writeback request
  logic      mem_valid;
  reg_addr_t mem_rd;
  xdata_t    mem_data;
  logic      mem_ready;

  // Register file write port and operand forwarding
  logic      wb_wren;
  reg_addr_t wb_rd;
  xdata_t    wb_data;
  logic      byp1_hit;
  logic      byp2_hit;

  modport slave (
    input  issue_valid, issue_rd_we, issue_rd, issue_rs1, issue_rs2,
    input  exec_valid, exec_rd, exec_data,
    input  mem_valid, mem_rd, mem_data,
    output stall, exec_ready, mem_ready,
    output wb_wren, wb_rd, wb_data, byp1_hit, byp2_hit
  );

  modport master (
    output issue_valid, issue_rd_we, issue_rd, issue_rs1, issue_rs2,
    output exec_valid, exec_rd, exec_data,
    output mem_valid, mem_rd, mem_data,
    input  stall, exec_ready, mem_ready,
    input  wb_wren, wb_rd, wb_data, byp1_hit, byp2_hit
  );

endinterface

// File: rtl/reg_wb_arbiter_wb_scoreboard.sv
// Per-register busy scoreboard: set on accepted issue, cleared on register
// file write, and RAW/WAW hazard detection for the issuing instruction.
// Optional feature macro: WB_BYPASS_EN (operands matching the in-flight
// register-file write are forwarded instead of stalling).
module wb_scoreboard
  import reg_wb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      issue_valid,
  input  logic      issue_rd_we,
  input  reg_addr_t issue_rd,
  input  reg_addr_t issue_rs1,
  input  reg_addr_t issue_rs2,
  input  logic      wb_wren,
  input  reg_addr_t wb_rd,
  output logic      stall,
  output logic      byp1_hit,
  output logic      byp2_hit
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            rs1_haz;
  logic            rs2_haz;
  logic            rd_haz;
  logic            set_en;

`ifdef WB_BYPASS_EN
  // wb_wren already implies wb_rd != 0, so x0 never forwards.
  assign byp1_hit = wb_wren && (issue_rs1 == wb_rd);
  assign byp2_hit = wb_wren && (issue_rs2 == wb_rd);
`else
  assign byp1_hit = 1'b0;
  assign byp2_hit = 1'b0;
`endif

  // Hazard detection: a forwarded operand never stalls, WAW is never forwarded.
  always_comb begin
    rs1_haz = busy_q[issue_rs1] && (issue_rs1 != '0) && !byp1_hit;
    rs2_haz = busy_q[issue_rs2] && (issue_rs2 != '0) && !byp2_hit;
    rd_haz  = issue_rd_we && busy_q[issue_rd] && (issue_rd != '0);
    stall   = issue_valid && (rs1_haz || rs2_haz || rd_haz);
    set_en  = issue_valid && !stall && issue_rd_we && (issue_rd != '0);
  end

  // Next busy vector: commit clears first so a same-cycle issue set wins.
  always_comb begin
    // NOTE: start from a full default so every path assigns busy_d and no latch is inferred.
    busy_d = busy_q;
    if (wb_wren) busy_d[wb_rd]    = 1'b0;
    if (set_en)  busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the scoreboard is control state, not a data array, so it must be reset; stale busy bits would deadlock issue.
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: round-robin between ALU and load
// writeback, registered register-file write port, busy scoreboard.
// Optional feature macro: WB_BYPASS_EN (operand bypass from wb_data).
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  reg_wb_arbiter_if.slave bus
);

  gnt_e      gnt;
  gnt_e      ptr_q;
  reg_addr_t sel_rd;
  xdata_t    sel_data;
  logic      wb_wren_q;
  reg_addr_t wb_rd_q;
  xdata_t    wb_data_q;

  // Grant: a lone request wins; on contention the pointer side wins.
  always_comb begin
    gnt = GNT_NONE;
    if (bus.exec_valid && bus.mem_valid) gnt = ptr_q;
    else if (bus.exec_valid)             gnt = GNT_EXEC;
    else if (bus.mem_valid)              gnt = GNT_MEM;
  end

  // Mux the granted source toward the output register.
  always_comb begin
    sel_rd   = (gnt == GNT_MEM) ? bus.mem_rd   : bus.exec_rd;
    sel_data = (gnt == GNT_MEM) ? bus.mem_data : bus.exec_data;
  end

  assign bus.exec_ready = (gnt == GNT_EXEC);
  assign bus.mem_ready  = (gnt == GNT_MEM);

  // Round-robin pointer: after any grant, priority passes to the other source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= GNT_MEM;
    end else if (gnt != GNT_NONE) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      ptr_q <= other_src(gnt);
    end
  end

  // Output register: capture the granted write; x0 writes are dropped via wren.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_wren_q <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else if (gnt != GNT_NONE) begin
      wb_wren_q <= (sel_rd != '0);
      wb_rd_q   <= sel_rd;
      wb_data_q <= sel_data;
    end else begin
      wb_wren_q <= 1'b0;
    end
  end

  assign bus.wb_wren = wb_wren_q;
  assign bus.wb_rd   = wb_rd_q;
  assign bus.wb_data = wb_data_q;

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (bus.issue_valid),
    .issue_rd_we (bus.issue_rd_we),
    .issue_rd    (bus.issue_rd),
    .issue_rs1   (bus.issue_rs1),
    .issue_rs2   (bus.issue_rs2),
    .wb_wren     (wb_wren_q),
    .wb_rd       (wb_rd_q),
    .stall       (bus.stall),
    .byp1_hit    (bus.byp1_hit),
    .byp2_hit    (bus.byp2_hit)
  );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
// Optional feature macro: WB_BYPASS_EN (expectations follow the build).
module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  reg_wb_arbiter_if bus ();

  reg_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: busy set, whose-turn flag, last register-file write.
  bit          busy_m [NREG];
  bit          mem_turn_m;
  bit          wren_m;
  int          rd_m;
  logic [31:0] data_m;

  // Expected combinational outputs for the current inputs.
  bit e_stall, e_gexec, e_gmem, e_byp1, e_byp2;

  task automatic model_reset();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    mem_turn_m = 1'b1;
    wren_m     = 1'b0;
    rd_m       = 0;
    data_m     = '0;
  endtask

  task automatic predict();
    int  rs1, rs2, rd;
    bit  ev, mv, hz1, hz2, hzd;
    rs1 = int'(bus.issue_rs1);
    rs2 = int'(bus.issue_rs2);
    rd  = int'(bus.issue_rd);
    ev  = bus.exec_valid;
    mv  = bus.mem_valid;
    e_byp1  = BYP && wren_m && (rs1 == rd_m);
    e_byp2  = BYP && wren_m && (rs2 == rd_m);
    hz1     = (rs1 != 0) && busy_m[rs1] && !e_byp1;
    hz2     = (rs2 != 0) && busy_m[rs2] && !e_byp2;
    hzd     = bus.issue_rd_we && (rd != 0) && busy_m[rd];
    e_stall = bus.issue_valid && (hz1 || hz2 || hzd);
    e_gexec = ev && (!mv || !mem_turn_m);
    e_gmem  = mv && (!ev || mem_turn_m);
  endtask

  // Let inputs settle, then compare every output with the model.
  task automatic settle();
    #1;
    predict();
    check("stall",      bus.stall,      e_stall);
    check("exec_ready", bus.exec_ready, e_gexec);
    check("mem_ready",  bus.mem_ready,  e_gmem);
    check("byp1_hit",   bus.byp1_hit,   e_byp1);
    check("byp2_hit",   bus.byp2_hit,   e_byp2);
    check("wb_wren",    bus.wb_wren,    wren_m);
    check("wb_rd",      bus.wb_rd,      rd_m);
    check("wb_data",    bus.wb_data,    data_m);
  endtask

  // Advance the model by one clock, then move to the next falling edge.
  task automatic tick();
    int rd;
    bit set;
    rd  = int'(bus.issue_rd);
    set = bus.issue_valid && !e_stall && bus.issue_rd_we && (rd != 0);
    if (wren_m) busy_m[rd_m] = 1'b0;
    if (set)    busy_m[rd]   = 1'b1;
    if (e_gexec) begin
      mem_turn_m = 1'b1;
      wren_m     = (bus.exec_rd != 0);
      rd_m       = int'(bus.exec_rd);
      data_m     = bus.exec_data;
    end else if (e_gmem) begin
      mem_turn_m = 1'b0;
      wren_m     = (bus.mem_rd != 0);
      rd_m       = int'(bus.mem_rd);
      data_m     = bus.mem_data;
    end else begin
      wren_m = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv_issue(input bit v, input bit we, input int rd, input int rs1, input int rs2);
    bus.issue_valid = v;
    bus.issue_rd_we = we;
    bus.issue_rd    = reg_addr_t'(rd);
    bus.issue_rs1   = reg_addr_t'(rs1);
    bus.issue_rs2   = reg_addr_t'(rs2);
  endtask

  task automatic drv_exec(input bit v, input int rd, input logic [31:0] d);
    bus.exec_valid = v;
    bus.exec_rd    = reg_addr_t'(rd);
    bus.exec_data  = d;
  endtask

  task automatic drv_mem(input bit v, input int rd, input logic [31:0] d);
    bus.mem_valid = v;
    bus.mem_rd    = reg_addr_t'(rd);
    bus.mem_data  = d;
  endtask

  task automatic idle();
    drv_issue(0, 0, 0, 0, 0);
    drv_exec(0, 0, '0);
    drv_mem(0, 0, '0);
  endtask

  // Asynchronous reset asserted away from any clock edge; outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_wb_wren", bus.wb_wren, 0);
    check("rst_wb_rd",   bus.wb_rd,   0);
    check("rst_wb_data", bus.wb_data, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_rd   [3];
    bit exp_mem  [3];
    exp_rd  = '{4, 3, 4};
    exp_mem = '{1'b1, 1'b0, 1'b1};

    idle();
    #2;
    do_reset();
    settle();
    check("rst_stall", bus.stall, 0);
    tick();

    // RAW on rd=5, resolved by an ALU writeback of 0xDEADBEEF.
    drv_issue(1, 1, 5, 0, 0);
    settle();
    check("t1_issue_accepted", bus.stall, 0);
    tick();
    drv_issue(1, 0, 0, 5, 0);
    drv_exec(1, 5, 32'hDEAD_BEEF);
    settle();
    check("t1_raw_stall", bus.stall, 1);
    check("t1_exec_grant", bus.exec_ready, 1);
    tick();
    drv_exec(0, 0, '0);
    settle();
    check("t1_wren_n1", bus.wb_wren, 1);
    check("t1_rd_n1",   bus.wb_rd,   5);
    check("t1_data_n1", bus.wb_data, 32'hDEAD_BEEF);
    check("t1_stall_n1", bus.stall, !BYP);
    check("t1_byp1_n1",  bus.byp1_hit, BYP);
    tick();
    settle();
    check("t1_stall_n2", bus.stall, 0);
    check("t1_byp1_n2",  bus.byp1_hit, 0);
    tick();
    idle();

    // Contention right after reset: mem, exec, mem.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        drv_exec(1, 3, 32'h0000_0033);
        drv_mem(1, 4, 32'h0000_0044);
      end else begin
        idle();
      end
      settle();
      if (k < 3) begin
        check("t2_mem_grant",  bus.mem_ready,  exp_mem[k]);
        check("t2_exec_grant", bus.exec_ready, !exp_mem[k]);
      end
      if (k > 0) check("t2_wb_rd", bus.wb_rd, exp_rd[k-1]);
      tick();
    end

    // Write to x0 is granted and discarded.
    drv_exec(1, 0, 32'h0000_1234);
    settle();
    check("t3_x0_grant", bus.exec_ready, 1);
    tick();
    idle();
    drv_issue(1, 1, 1, 0, 0);
    settle();
    check("t3_x0_no_wren", bus.wb_wren, 0);
    check("t3_x0_no_stall", bus.stall, 0);
    tick();
    idle();

    // Commit clear and issue set hit x7 in the same cycle: set wins.
    drv_exec(1, 7, 32'h0000_0077);
    settle();
    tick();
    drv_exec(0, 0, '0);
    drv_issue(1, 1, 7, 0, 0);
    settle();
    check("t4_commit_x7", bus.wb_rd, 7);
    check("t4_issue_ok", bus.stall, 0);
    tick();
    drv_issue(1, 0, 0, 0, 7);
    settle();
    check("t4_set_wins", bus.stall, 1);
    tick();
    idle();

    // Reset while a write is in flight and x9 is busy.
    drv_issue(1, 1, 9, 0, 0);
    settle();
    tick();
    idle();
    drv_exec(1, 12, 32'h0000_CAFE);
    settle();
    tick();
    idle();
    drv_issue(1, 0, 0, 9, 0);
    settle();
    check("t5_wren_before", bus.wb_wren, 1);
    check("t5_busy9_before", bus.stall, 1);
    do_reset();
    settle();
    check("t5_busy9_after", bus.stall, 0);
    tick();
    idle();

    // Randomized traffic on a small register window to provoke hazards.
    for (int c = 0; c < 800; c++) begin
      int hi;
      hi = ($urandom_range(0, 9) == 0) ? NREG - 1 : 7;
      drv_issue($urandom_range(0, 9) < 6, $urandom_range(0, 1),
                $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
      drv_exec($urandom_range(0, 2) == 0, $urandom_range(0, hi), $urandom);
      drv_mem($urandom_range(0, 2) == 0, $urandom_range(0, hi), $urandom);
      if (c == 400) do_reset();
      settle();
      tick();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
